// File: rtl/avr_cpu.sv
// avr_cpu: single-cycle AVR-subset core with 32x8 register file, ALU and SREG; fetch is external via p_addr/instr.
module avr_cpu #(
   parameter int PC_W = 16,
   parameter int DA_W = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [15:0]     instr,
   output logic [PC_W-1:0] p_addr,
   output logic [DA_W-1:0] d_addr,
   output logic [7:0]      S_reg,
   output logic [7:0]      Rr_do,
   output logic [7:0]      Rd_do,
   output logic [7:0]      Rd_di
);
   logic [7:0]      regs_q [32];
   logic [7:0]      regs_d [32];
   logic [7:0]      sreg_q, sreg_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [5:0]      op6;
   logic [3:0]      op4, sop;
   logic [4:0]      d, r;
   logic [7:0]      k, a, b, res;
   logic [8:0]      sum, diff;
   logic            two_op, imm_op, add_op, sub_op, cin_op, log_op, cmp_op, one_op, c_in;
   logic            wr, fl, h, v, c, z;
   always_comb begin
      op6    = instr[15:10];
      op4    = instr[15:12];
      sop    = instr[3:0];
      two_op = op6 inside {6'b000011, 6'b000111, 6'b000110, 6'b000010, 6'b001000,
                           6'b001001, 6'b001010, 6'b001011, 6'b000101, 6'b000001};
      imm_op = op4 inside {4'b1110, 4'b0101, 4'b0100, 4'b0111, 4'b0110, 4'b0011};
      add_op = op6 inside {6'b000011, 6'b000111};
      sub_op = op6 inside {6'b000110, 6'b000010, 6'b000101, 6'b000001} || op4 inside {4'b0101, 4'b0100, 4'b0011};
      cin_op = op6 inside {6'b000111, 6'b000010, 6'b000001} || op4 == 4'b0100;
      log_op = op6 inside {6'b001000, 6'b001001, 6'b001010} || op4 inside {4'b0111, 4'b0110};
      cmp_op = op6 inside {6'b000101, 6'b000001} || op4 == 4'b0011;
      one_op = instr[15:9] == 7'b1001010 && sop inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA};
      d      = imm_op ? {1'b1, instr[7:4]} : instr[8:4];
      r      = {instr[9], instr[3:0]};
      k      = {instr[11:8], instr[3:0]};
      a      = regs_q[d];
      Rr_do  = two_op ? regs_q[r] : 8'h00;
      b      = imm_op ? k : Rr_do;
      c_in   = cin_op & sreg_q[0];
      sum    = {1'b0, a} + {1'b0, b} + {8'h00, c_in};
      diff   = {1'b0, a} - {1'b0, b} - {8'h00, c_in};
      res    = 8'h00;
      h      = sreg_q[5];
      v      = sreg_q[3];
      c      = sreg_q[0];
      wr     = 1'b0;
      fl     = 1'b0;
      if (add_op) begin
         res = sum[7:0];
         h   = a[3] & b[3] | b[3] & ~res[3] | ~res[3] & a[3];
         v   = a[7] & b[7] & ~res[7] | ~a[7] & ~b[7] & res[7];
         c   = sum[8];
         wr  = 1'b1;
         fl  = 1'b1;
      end else if (sub_op) begin
         res = diff[7:0];
         h   = ~a[3] & b[3] | b[3] & res[3] | res[3] & ~a[3];
         v   = a[7] & ~b[7] & ~res[7] | ~a[7] & b[7] & res[7];
         c   = diff[8];
         wr  = ~cmp_op;
         fl  = 1'b1;
      end else if (log_op) begin
         res = (op6 == 6'b001000 || op4 == 4'b0111) ? a & b : (op6 == 6'b001001) ? a ^ b : a | b;
         v   = 1'b0;
         wr  = 1'b1;
         fl  = 1'b1;
      end else if (op6 == 6'b001011 || op4 == 4'b1110) begin
         res = b;
         wr  = 1'b1;
      end else if (one_op) begin
         wr = 1'b1;
         fl = sop != 4'h2;
         case (sop)
            4'h0: begin res = ~a; c = 1'b1; v = 1'b0; end
            4'h1: begin res = 8'h00 - a; h = a[3] | res[3]; c = res != 8'h00; v = res == 8'h80; end
            4'h2: res = {a[3:0], a[7:4]};
            4'h3: begin res = a + 8'h01; v = res == 8'h80; end
            4'h5: begin res = {a[7], a[7:1]}; c = a[0]; v = res[7] ^ c; end
            4'h6: begin res = {1'b0, a[7:1]}; c = a[0]; v = c; end
            4'h7: begin res = {sreg_q[0], a[7:1]}; c = a[0]; v = res[7] ^ c; end
            default: begin res = a - 8'h01; v = res == 8'h7F; end
         endcase
      end
      // carry-chained subtracts only keep Z set if every byte so far was zero
      z      = res == 8'h00 && (!(cin_op && sub_op) || sreg_q[1]);
      sreg_d = fl ? {sreg_q[7:6], h, res[7] ^ v, v, res[7], z, c} : sreg_q;
      Rd_do  = a;
      Rd_di  = wr ? res : 8'h00;
      regs_d = regs_q;
      if (wr) regs_d[d] = res;
      pc_d   = pc_q + PC_W'(1);
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         regs_q <= '{default: 8'h00};
         sreg_q <= 8'h00;
         pc_q   <= '0;
      end else begin
         regs_q <= regs_d;
         sreg_q <= sreg_d;
         pc_q   <= pc_d;
      end
   end
   assign p_addr = pc_q;
   assign d_addr = DA_W'({regs_q[27], regs_q[26]});
   assign S_reg  = sreg_q;
endmodule

// File: tb/tb_avr_cpu.sv
// tb_avr_cpu: directed instruction stream; expected taps queued per cycle and checked mid-cycle by a monitor.
module tb_avr_cpu;
   typedef struct {
      int          idx;
      logic [5:0]  m;
      logic [7:0]  di, rd, rr, sr;
      logic [15:0] pc, da;
   } exp_t;
   localparam logic [5:0] M_N = 6'b110110;
   localparam logic [5:0] M_R = 6'b111110;
   localparam logic [5:0] M_D = 6'b110111;
   logic        CLK = 1'b0, RST = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic [15:0] p_addr, d_addr;
   logic [7:0]  S_reg, Rr_do, Rd_do, Rd_di;
   exp_t        q[$];
   int          total = 0, bad = 0, row = 0;
   avr_cpu dut (
      .CLK(CLK), .RST(RST), .instr(instr), .p_addr(p_addr), .d_addr(d_addr),
      .S_reg(S_reg), .Rr_do(Rr_do), .Rd_do(Rd_do), .Rd_di(Rd_di)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask
   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.m[5]) chk("Rd_di", e.idx, {8'h00, Rd_di}, {8'h00, e.di});
         if (e.m[4]) chk("Rd_do", e.idx, {8'h00, Rd_do}, {8'h00, e.rd});
         if (e.m[3]) chk("Rr_do", e.idx, {8'h00, Rr_do}, {8'h00, e.rr});
         if (e.m[2]) chk("S_reg", e.idx, {8'h00, S_reg}, {8'h00, e.sr});
         if (e.m[1]) chk("p_addr", e.idx, p_addr, e.pc);
         if (e.m[0]) chk("d_addr", e.idx, d_addr, e.da);
      end
   end
   task automatic v(input logic r, input logic [15:0] i, input logic [5:0] m, input logic [7:0] di,
                    input logic [7:0] rd, input logic [7:0] rr, input logic [7:0] sr,
                    input logic [15:0] pc, input logic [15:0] da);
      exp_t e;
      @(posedge CLK);
      #1;
      RST   = r;
      instr = i;
      e = '{idx: row, m: m, di: di, rd: rd, rr: rr, sr: sr, pc: pc, da: da};
      q.push_back(e);
      row++;
   endtask
   initial begin
      v(0, 16'h0000, 6'b0,        8'h00, 8'h00, 8'h00, 8'h00, 16'd0,  16'h0000);
      v(1, 16'h01F0, M_D,         8'h00, 8'h00, 8'h00, 8'h00, 16'd0,  16'h0000);
      v(1, 16'h0000, M_N,         8'h00, 8'h00, 8'h00, 8'h00, 16'd1,  16'h0000);
      v(1, 16'h50A1, M_R | M_D,   8'hFF, 8'h00, 8'h00, 8'h00, 16'd2,  16'h0000);
      v(1, 16'h50A2, M_D,         8'hFD, 8'hFF, 8'h00, 8'h35, 16'd3,  16'h00FF);
      v(1, 16'h50A0, M_D,         8'hFD, 8'hFD, 8'h00, 8'h14, 16'd4,  16'h00FD);
      v(1, 16'hE800, M_D,         8'h80, 8'h00, 8'h00, 8'h14, 16'd5,  16'h00FD);
      v(1, 16'hE011, M_N,         8'h01, 8'h00, 8'h00, 8'h14, 16'd6,  16'h0000);
      v(1, 16'h0F01, M_R,         8'h81, 8'h80, 8'h01, 8'h14, 16'd7,  16'h0000);
      v(1, 16'hEF0F, M_N,         8'hFF, 8'h81, 8'h00, 8'h14, 16'd8,  16'h0000);
      v(1, 16'h0F00, M_R,         8'hFE, 8'hFF, 8'hFF, 8'h14, 16'd9,  16'h0000);
      v(1, 16'hE70F, M_N,         8'h7F, 8'hFE, 8'h00, 8'h35, 16'd10, 16'h0000);
      v(1, 16'h9503, M_N,         8'h80, 8'h7F, 8'h00, 8'h35, 16'd11, 16'h0000);
      v(1, 16'h3800, M_N,         8'h00, 8'h80, 8'h00, 8'h2D, 16'd12, 16'h0000);
      v(1, 16'hE015, M_N,         8'h05, 8'h01, 8'h00, 8'h02, 16'd13, 16'h0000);
      v(1, 16'h3013, M_N,         8'h00, 8'h05, 8'h00, 8'h02, 16'd14, 16'h0000);
      v(1, 16'h4015, M_N,         8'h00, 8'h05, 8'h00, 8'h00, 16'd15, 16'h0000);
      v(1, 16'h0110, M_N,         8'h00, 8'h00, 8'h00, 8'h00, 16'd16, 16'h0000);
      v(1, 16'h0100, M_N,         8'h00, 8'h80, 8'h00, 8'h00, 16'd17, 16'h0000);
      v(1, 16'hE011, M_N,         8'h01, 8'h00, 8'h00, 8'h00, 16'd18, 16'h0000);
      v(1, 16'h1B01, M_R,         8'h7F, 8'h80, 8'h01, 8'h00, 16'd19, 16'h0000);
      v(1, 16'h1F01, M_R,         8'h80, 8'h7F, 8'h01, 8'h38, 16'd20, 16'h0000);
      v(1, 16'h2700, M_R,         8'h00, 8'h80, 8'h80, 8'h2C, 16'd21, 16'h0000);
      v(1, 16'h9500, M_N,         8'hFF, 8'h00, 8'h00, 8'h22, 16'd22, 16'h0000);
      v(1, 16'h9506, M_N,         8'h7F, 8'hFF, 8'h00, 8'h35, 16'd23, 16'h0000);
      v(1, 16'h9501, M_N,         8'h81, 8'h7F, 8'h00, 8'h39, 16'd24, 16'h0000);
      v(1, 16'h9502, M_N,         8'h18, 8'h81, 8'h00, 8'h35, 16'd25, 16'h0000);
      v(1, 16'h9507, M_N,         8'h8C, 8'h18, 8'h00, 8'h35, 16'd26, 16'h0000);
      v(1, 16'h9505, M_N,         8'hC6, 8'h8C, 8'h00, 8'h2C, 16'd27, 16'h0000);
      v(1, 16'h950A, M_N,         8'hC5, 8'hC6, 8'h00, 8'h2C, 16'd28, 16'h0000);
      v(1, 16'h2E00, M_R,         8'hC5, 8'h00, 8'hC5, 8'h34, 16'd29, 16'h0000);
      v(1, 16'h1601, M_R,         8'h00, 8'hC5, 8'h01, 8'h34, 16'd30, 16'h0000);
      v(0, 16'hE505, 6'b010110,   8'h00, 8'hC5, 8'h00, 8'h14, 16'd31, 16'h0000);
      v(1, 16'h0100, M_D,         8'h00, 8'h00, 8'h00, 8'h00, 16'd0,  16'h0000);
      v(1, 16'hEF20, M_N,         8'hF0, 8'h00, 8'h00, 8'h00, 16'd1,  16'h0000);
      v(1, 16'h602F, M_N,         8'hFF, 8'hF0, 8'h00, 8'h00, 16'd2,  16'h0000);
      v(1, 16'h7820, M_N,         8'h80, 8'hFF, 8'h00, 8'h14, 16'd3,  16'h0000);
      v(1, 16'hE830, M_N,         8'h80, 8'h00, 8'h00, 8'h14, 16'd4,  16'h0000);
      v(1, 16'h1723, M_R,         8'h00, 8'h80, 8'h80, 8'h14, 16'd5,  16'h0000);
      v(1, 16'h0B23, M_R,         8'h00, 8'h80, 8'h80, 8'h02, 16'd6,  16'h0000);
      v(1, 16'h2B23, M_R,         8'h80, 8'h00, 8'h80, 8'h02, 16'd7,  16'h0000);
      v(1, 16'h2323, M_R,         8'h80, 8'h80, 8'h80, 8'h14, 16'd8,  16'h0000);
      v(1, 16'h0000, M_N,         8'h00, 8'h00, 8'h00, 8'h14, 16'd9,  16'h0000);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
